// File: rtl/seg_pkg.sv
// Shared types, constants and helpers for the seven-segment circle animation.
package seg_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] POS_MIN = SEL_W'(1);
  localparam logic [SEL_W-1:0] POS_MAX = SEL_W'(8);

  // Segment patterns as {g,f,e,d,c,b,a}, active high: upper square a,b,f,g; lower square c,d,e,g.
  localparam logic [SEG_W-1:0] PAT_UPPER = 7'b1100011;
  localparam logic [SEG_W-1:0] PAT_LOWER = 7'b1011100;

  // Position to one-hot digit: out along the top row, back along the bottom row.
  function automatic logic [DIG_W-1:0] pos_to_digit(input logic [SEL_W-1:0] pos);
    logic [DIG_W-1:0] dig;
    dig = '0;
    case (pos)
      4'd1, 4'd8: dig = 4'b0001;
      4'd2, 4'd7: dig = 4'b0010;
      4'd3, 4'd6: dig = 4'b0100;
      4'd4, 4'd5: dig = 4'b1000;
      default:    dig = '0;
    endcase
    return dig;
  endfunction

  // Position to segment pattern, as used by the decoder side.
  function automatic logic [SEG_W-1:0] pos_to_pattern(input logic [SEL_W-1:0] pos);
    logic [SEG_W-1:0] pat;
    pat = '0;
    if (pos >= POS_MIN && pos <= SEL_W'(4)) begin
      pat = PAT_UPPER;
    end else if (pos >= SEL_W'(5) && pos <= POS_MAX) begin
      pat = PAT_LOWER;
    end
    return pat;
  endfunction

endpackage

// File: rtl/seg_circle_ctrl_if.sv
// Control and display-drive signals between board control logic and the sequencer.
interface seg_circle_ctrl_if;
  import seg_pkg::*;

  logic             start;
  logic             stop;
  logic             hold;
  logic             dir;
  logic [SEL_W-1:0] sel;
  logic [DIG_W-1:0] dig_sel;
  logic             blank;
  logic             busy;
  logic             lap_pulse;
  logic             done;

  modport master (
    output start, stop, hold, dir,
    input  sel, dig_sel, blank, busy, lap_pulse, done
  );

  modport slave (
    input  start, stop, hold, dir,
    output sel, dig_sel, blank, busy, lap_pulse, done
  );
endinterface

// File: rtl/seg_tick_gen.sv
// Prescaler: counts 0..STEP_CYCLES-1 while enabled; tick_o is high while the count sits at
// its last value, so a consumer steps on (tick_o & en) and a held count keeps its place.
module seg_tick_gen #(
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;

  // Next count with wrap at the last value.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // Count register and terminal-count flag; clear wins over enable.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (en_i) begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/seg_circle_ctrl.sv
// Rotating-square sequencer: steps a position 1..8 and drives decoder select and digit enable.
module seg_circle_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter int unsigned LAPS        = 0,
  parameter int unsigned CNT_W       = 26
) (
  input  logic            clk,
  input  logic            rst,
  seg_circle_ctrl_if.slave bus
);

  localparam int unsigned LAP_W = (LAPS > 1) ? $clog2(LAPS + 1) : 1;

  state_e           state_q;
  logic [SEL_W-1:0] pos_q;
  logic [LAP_W-1:0] laps_q;
  logic [SEL_W-1:0] sel_q;
  logic [DIG_W-1:0] dig_sel_q;
  logic             blank_q;
  logic             busy_q;
  logic             lap_pulse_q;
  logic             done_q;

  logic             tick;
  logic             tick_clr_c;
  logic             tick_en_c;
  logic             step_c;
  logic             wrap_c;
  logic             limit_hit_c;
  logic [SEL_W-1:0] pos_d;
  logic [LAP_W-1:0] laps_d;

  // Prescaler is parked at zero in IDLE and restarted by start/stop.
  always_comb begin
    tick_clr_c = (state_q == ST_IDLE) || bus.start || bus.stop;
    tick_en_c  = (state_q == ST_RUN) && !bus.hold;
  end

  seg_tick_gen #(
    .STEP_CYCLES (STEP_CYCLES),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tick_clr_c),
    .en_i   (tick_en_c),
    .tick_o (tick)
  );

  // Next position per direction, wrap detection and lap-limit check.
  always_comb begin
    step_c = (state_q == ST_RUN) && !bus.hold && tick;
    if (bus.dir) begin
      wrap_c = (pos_q == POS_MIN);
      pos_d  = wrap_c ? POS_MAX : pos_q - SEL_W'(1);
    end else begin
      wrap_c = (pos_q == POS_MAX);
      pos_d  = wrap_c ? POS_MIN : pos_q + SEL_W'(1);
    end
    laps_d      = laps_q + LAP_W'(1);
    limit_hit_c = (LAPS != 0) && wrap_c && (laps_d == LAP_W'(LAPS));
  end

  // FSM with registered outputs; priority rst > stop > start > step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= POS_MIN;
      laps_q      <= '0;
      sel_q       <= POS_MIN;
      dig_sel_q   <= '0;
      blank_q     <= 1'b1;
      busy_q      <= 1'b0;
      lap_pulse_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      lap_pulse_q <= 1'b0;
      done_q      <= 1'b0;
      if (bus.stop) begin
        state_q   <= ST_IDLE;
        pos_q     <= POS_MIN;
        laps_q    <= '0;
        sel_q     <= POS_MIN;
        dig_sel_q <= '0;
        blank_q   <= 1'b1;
        busy_q    <= 1'b0;
      end else if (bus.start) begin
        state_q   <= ST_RUN;
        pos_q     <= POS_MIN;
        laps_q    <= '0;
        sel_q     <= POS_MIN;
        dig_sel_q <= pos_to_digit(POS_MIN);
        blank_q   <= 1'b0;
        busy_q    <= 1'b1;
      end else if (step_c) begin
        if (limit_hit_c) begin
          state_q     <= ST_IDLE;
          pos_q       <= POS_MIN;
          laps_q      <= '0;
          sel_q       <= POS_MIN;
          dig_sel_q   <= '0;
          blank_q     <= 1'b1;
          busy_q      <= 1'b0;
          lap_pulse_q <= 1'b1;
          done_q      <= 1'b1;
        end else begin
          pos_q       <= pos_d;
          sel_q       <= pos_d;
          dig_sel_q   <= pos_to_digit(pos_d);
          lap_pulse_q <= wrap_c;
          if (wrap_c) begin
            laps_q <= laps_d;
          end
        end
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.dig_sel   = dig_sel_q;
  assign bus.blank     = blank_q;
  assign bus.busy      = busy_q;
  assign bus.lap_pulse = lap_pulse_q;
  assign bus.done      = done_q;

endmodule
